// File: rtl/shared_resource_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and a
// single-cycle shared resource.
interface shared_resource_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req1_data;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic              rsp0_ready;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic [DATA_W-1:0] rsp1_data;
  logic [1:0]        res_in_valid;
  logic [DATA_W-1:0] res_in_data;
  logic [1:0]        res_out_valid;
  logic [DATA_W-1:0] res_out_data;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_data, req1_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp0_data, rsp1_data,
    input  rsp0_ready, rsp1_ready,
    output res_in_valid, res_in_data,
    input  res_out_valid, res_out_data
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_data, req1_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp0_data, rsp1_data,
    output rsp0_ready, rsp1_ready,
    input  res_in_valid, res_in_data,
    output res_out_valid, res_out_data
  );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Two-requester arbiter for a 1-cycle shared resource with 2-deep
// response FIFOs; SHARED_ARB_RR_EN selects round-robin, else fixed priority.
module shared_resource_arbiter #(
  parameter int DATA_W = 32
) (
  input logic                     clk,
  input logic                     reset,
  shared_resource_arbiter_if.slave bus
);

  logic [1:0]        w_req_v;
  logic [1:0]        w_rsp_rdy;
  logic [1:0]        w_pop;
  logic [1:0]        w_push;
  logic [1:0]        w_elig;
  logic [1:0]        w_grant;
  logic [1:0]        w_rspv;
  logic              w_tag_ok;
  logic [DATA_W-1:0] w_req_d [2];
  logic [DATA_W-1:0] w_head  [2];
  logic [DATA_W-1:0] w_res_d;

  assign w_req_v   = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_req_d[0] = bus.req0_data;
  assign w_req_d[1] = bus.req1_data;
  assign w_tag_ok  = (bus.res_out_valid != 2'b11);

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [1:0]        r_cnt;
    logic              r_wp;
    logic              r_rp;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem [2];
    logic [2:0]        w_load;
    logic [2:0]        w_lim;

    assign w_rspv[g] = (r_cnt != 2'd0);
    assign w_pop[g]  = w_rspv[g] & w_rsp_rdy[g];
    assign w_push[g] = bus.res_out_valid[g] & r_inflight & w_tag_ok;
    // Credit: buffered + in-flight, less what leaves this cycle.
    assign w_load    = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign w_lim     = 3'd2 + {2'b00, w_pop[g]};
    assign w_elig[g] = ~reset & w_req_v[g] & (w_load < w_lim);
    assign w_head[g] = w_rspv[g] ? r_mem[r_rp] : '0;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt      <= 2'd0;
        r_wp       <= 1'b0;
        r_rp       <= 1'b0;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_grant[g] | (r_inflight & ~w_push[g]);
        if (w_push[g]) r_wp <= ~r_wp;
        if (w_pop[g])  r_rp <= ~r_rp;
        unique case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wp] <= bus.res_out_data;
    end
  end

`ifdef SHARED_ARB_RR_EN
  logic r_ptr;

  always_comb begin
    w_grant = w_elig;
    if (&w_elig) w_grant = r_ptr ? 2'b10 : 2'b01;
  end

  // After any grant the other requester gets the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (|w_grant) begin
      r_ptr <= w_grant[0];
    end
  end
`else
  always_comb begin
    w_grant = w_elig;
    if (w_elig[0]) w_grant = 2'b01;
  end
`endif

  always_comb begin
    w_res_d = '0;
    unique case (1'b1)
      w_grant[0]: w_res_d = w_req_d[0];
      w_grant[1]: w_res_d = w_req_d[1];
      default:    w_res_d = '0;
    endcase
  end

  assign bus.req0_ready   = w_grant[0];
  assign bus.req1_ready   = w_grant[1];
  assign bus.res_in_valid = w_grant;
  assign bus.res_in_data  = w_res_d;
  assign bus.rsp0_valid   = w_rspv[0];
  assign bus.rsp1_valid   = w_rspv[1];
  assign bus.rsp0_data    = w_head[0];
  assign bus.rsp1_data    = w_head[1];

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Randomized bench for shared_resource_arbiter against a queue-level
// model; the resource here doubles its operand with 1-cycle latency.
module tb_shared_resource_arbiter;
  localparam int DW = 32;
  localparam int VW = 6 + 3 * DW;
  typedef logic [VW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          inj;
  logic [1:0]    tv;
  logic [1:0]    tr;
  logic [DW-1:0] td [2];

  shared_resource_arbiter_if #(.DATA_W(DW)) bus ();

  shared_resource_arbiter #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.req0_valid = tv[0];
  assign bus.req1_valid = tv[1];
  assign bus.req0_data  = td[0];
  assign bus.req1_data  = td[1];
  assign bus.rsp0_ready = tr[0];
  assign bus.rsp1_ready = tr[1];

  always @(posedge clk) begin
    bus.res_out_valid <= inj ? 2'b11 : bus.res_in_valid;
    bus.res_out_data  <= bus.res_in_data << 1;
  end

  int checks;
  int errors;

  // Model: per-requester list of owed results with the cycle they appear.
  logic [DW-1:0] md [2][4];
  int            mt [2][4];
  int            mn [2];
  int            cyc;
  int            mg;
`ifdef SHARED_ARB_RR_EN
  bit            m_ptr;
`endif
  logic [1:0]    e_rdy;
  logic [1:0]    e_riv;
  logic [1:0]    e_rspv;
  logic [1:0]    e_pop;
  logic [DW-1:0] e_rid;
  logic [DW-1:0] e_rspd [2];

  task automatic model_reset();
    mn[0] = 0;
    mn[1] = 0;
    cyc = 0;
`ifdef SHARED_ARB_RR_EN
    m_ptr = 1'b0;
`endif
  endtask

  task automatic model_eval();
    logic [1:0] el;
    el = 2'b00;
    for (int i = 0; i < 2; i++) begin
      e_rspv[i] = (mn[i] > 0) && (mt[i][0] <= cyc);
      e_rspd[i] = e_rspv[i] ? md[i][0] : '0;
      e_pop[i]  = e_rspv[i] && tr[i];
      el[i]     = tv[i] && ((mn[i] - int'(e_pop[i])) < 2);
    end
    mg = -1;
    if (el == 2'b11) begin
`ifdef SHARED_ARB_RR_EN
      mg = int'(m_ptr);
`else
      mg = 0;
`endif
    end else if (el[0]) begin
      mg = 0;
    end else if (el[1]) begin
      mg = 1;
    end
    e_rdy = 2'b00;
    e_riv = 2'b00;
    e_rid = '0;
    if (mg >= 0) begin
      e_rdy[mg] = 1'b1;
      e_riv[mg] = 1'b1;
      e_rid     = td[mg];
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 2; i++) begin
      if (e_pop[i]) begin
        for (int j = 0; j < 3; j++) begin
          md[i][j] = md[i][j+1];
          mt[i][j] = mt[i][j+1];
        end
        mn[i] = mn[i] - 1;
      end
    end
    if (mg >= 0) begin
      md[mg][mn[mg]] = td[mg] << 1;
      mt[mg][mn[mg]] = cyc + 2;
      mn[mg] = mn[mg] + 1;
`ifdef SHARED_ARB_RR_EN
      m_ptr = (mg == 0);
`endif
    end
    cyc = cyc + 1;
  endtask

  function automatic vec_t observe();
    return {bus.req1_ready, bus.req0_ready, bus.res_in_valid,
            bus.rsp1_valid, bus.rsp0_valid, bus.res_in_data,
            bus.rsp0_data, bus.rsp1_data};
  endfunction

  function automatic vec_t expv();
    return {e_rdy, e_riv, e_rspv, e_rid, e_rspd[0], e_rspd[1]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tv = 2'b00;
    tr = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tv = 2'b11;
    tr = 2'b11;
    td[0] = $urandom;
    td[1] = $urandom;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (observe() !== '0) begin
        errors++;
        $display("FAIL reset_outputs got=%h want=0", observe());
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tv = 2'b00;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tv = (k == 0) ? 2'b01 : 2'b00;
      tr = (k >= 2) ? 2'b01 : 2'b00;
      td[0] = (k == 0) ? 32'd5 : $urandom;
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL single_model k=%0d got=%h want=%h", k, observe(), expv());
      end
      if (k == 0) begin
        checks++;
        if (bus.res_in_valid !== 2'b01 || bus.res_in_data !== 32'd5) begin
          errors++;
          $display("FAIL single_issue tag=%b data=%0d want tag=01 data=5",
                   bus.res_in_valid, bus.res_in_data);
        end
      end
      if (k == 1) begin
        checks++;
        if (bus.rsp0_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_early rsp0_valid=%b want 0", bus.rsp0_valid);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 32'd10) begin
          errors++;
          $display("FAIL single_rsp valid=%b data=%0d want valid=1 data=10",
                   bus.rsp0_valid, bus.rsp0_data);
        end
      end
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tv = 2'b11;
      tr = 2'b11;
      td[0] = $urandom;
      td[1] = $urandom;
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL b2b_model k=%0d got=%h want=%h", k, observe(), expv());
      end
`ifdef SHARED_ARB_RR_EN
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b01;
`endif
      checks++;
      if (bus.res_in_valid !== want) begin
        errors++;
        $display("FAIL b2b_grant k=%0d got=%b want=%b", k, bus.res_in_valid, want);
      end
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  task automatic test_backpressure();
    int nsent;
    int acc;
    int ng;
    logic [DW-1:0] got [4];
    nsent = 0;
    acc = 0;
    ng = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tv = (nsent < 3) ? 2'b10 : 2'b00;
      tr = (k >= 6) ? 2'b10 : 2'b00;
      td[1] = DW'(nsent + 1);
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL bp_model k=%0d got=%h want=%h", k, observe(), expv());
      end
      if (bus.rsp1_valid === 1'b1 && tr[1] && ng < 4) begin
        got[ng] = bus.rsp1_data;
        ng++;
      end
      if (bus.req1_ready === 1'b1) begin
        nsent++;
        if (k < 6) acc++;
      end
      if (k == 5) begin
        checks++;
        if (acc !== 2 || bus.rsp1_data !== 32'd2) begin
          errors++;
          $display("FAIL bp_stall accepted=%0d head=%0d want 2 and 2",
                   acc, bus.rsp1_data);
        end
      end
      @(posedge clk);
      model_commit();
      #1;
    end
    checks++;
    if (ng !== 3 || got[0] !== 32'd2 || got[1] !== 32'd4 || got[2] !== 32'd6) begin
      errors++;
      $display("FAIL bp_order n=%0d got=%0d,%0d,%0d want 3: 2,4,6",
               ng, got[0], got[1], got[2]);
    end
  endtask

  task automatic test_inject();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      inj = (k == 0);
      tv = (k >= 4) ? 2'b11 : 2'b00;
      tr = 2'b11;
      td[0] = $urandom;
      td[1] = $urandom;
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL inject k=%0d got=%h want=%h", k, observe(), expv());
      end
      @(posedge clk);
      model_commit();
      #1;
    end
    inj = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      tv = 2'b01;
      tr = 2'b00;
      td[0] = (k == 0) ? 32'd7 : 32'd9;
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL rmid_fill k=%0d got=%h want=%h", k, observe(), expv());
      end
      @(posedge clk);
      model_commit();
      #1;
    end
    reset = 1'b1;
    tv = 2'b11;
    tr = 2'b11;
    @(negedge clk);
    checks++;
    if (observe() !== '0) begin
      errors++;
      $display("FAIL rmid_reset got=%h want=0", observe());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 7; k++) begin
      tv = (k == 6) ? 2'b11 : 2'b00;
      td[0] = $urandom;
      td[1] = $urandom;
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL rmid_after k=%0d got=%h want=%h", k, observe(), expv());
      end
      if (k == 6) begin
        checks++;
        if (bus.res_in_valid !== 2'b01) begin
          errors++;
          $display("FAIL rmid_ptr got=%b want=01", bus.res_in_valid);
        end
      end
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tv = 2'($urandom);
      tr[0] = ($urandom_range(0, 3) != 0);
      tr[1] = ($urandom_range(0, 2) == 0);
      td[0] = $urandom;
      td[1] = $urandom;
      @(negedge clk);
      model_eval();
      checks++;
      if (observe() !== expv()) begin
        errors++;
        $display("FAIL random k=%0d got=%h want=%h", k, observe(), expv());
      end
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    inj = 1'b0;
    tv = 2'b00;
    tr = 2'b00;
    td[0] = '0;
    td[1] = '0;
    reset = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_inject();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_resource_arbiter.md
SHARED_RESOURCE_ARBITER -- requirements
Module: shared_resource_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of request, response and resource data.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has a request.
REQ-005 req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-006 req0_data / req1_data  input  DATA_W  request operand.
REQ-007 rsp0_valid / rsp1_valid  output  1  response available.
REQ-008 rsp0_ready / rsp1_ready  input  1  requester consumes the response.
REQ-009 rsp0_data / rsp1_data  output  DATA_W  response data.
REQ-010 res_in_valid  output  2  one-hot requester tag driven to the shared resource.
REQ-011 res_in_data  output  DATA_W  operand driven to the shared resource.
REQ-012 res_out_valid  input  2  tag returned by the resource, exactly 1 cycle after issue.
REQ-013 res_out_data  input  DATA_W  result returned by the resource, aligned with res_out_valid.

Function
REQ-014 Each requester i SHALL own a 2-entry in-order response FIFO and an in-flight flag (inflight_i).
REQ-015 Requester i is eligible when reqi_valid=1 and occupancy_i + inflight_i - (rspi_valid & rspi_ready) < 2.
REQ-016 At most one grant per cycle; reqi_ready SHALL equal grant_i, combinational from the current eligibility and pointer.
REQ-017 When only one requester is eligible, it SHALL be granted.
REQ-018 When both are eligible, the round-robin pointer selects the grant; after any grant, the pointer SHALL point to the other requester.
REQ-019 On grant, res_in_valid SHALL be the one-hot tag of the granted requester and res_in_data its reqi_data, in the same cycle.
REQ-020 With no grant, res_in_valid SHALL be 2'b00 and res_in_data all-zero.
REQ-021 inflight_i SHALL set on the cycle after grant_i and clear when res_out_valid[i] is captured.
REQ-022 res_out_valid[i]=1 SHALL push res_out_data into FIFO i at that cycle's clock edge.
REQ-023 Latency: a request accepted in cycle t SHALL give rspi_valid=1 no earlier than cycle t+2 and exactly at t+2 if FIFO i was empty.
REQ-024 rspi_valid = FIFO i non-empty; rspi_data = FIFO i head, held stable until rspi_ready=1.
REQ-025 A simultaneous push and pop on FIFO i SHALL keep occupancy unchanged and preserve order.
REQ-026 Full FIFO i plus inflight_i=1 cannot occur; credit rule REQ-015 guarantees no overflow and no dropped result.
REQ-027 Sustained throughput: one grant per cycle overall, and one per cycle per requester while its consumer is always ready.
REQ-028 res_out_valid=2'b11 or an unexpected tag (inflight_i=0) SHALL be ignored and SHALL NOT push.

Reset
REQ-029 Reset SHALL empty both FIFOs, clear both inflight flags and set the pointer to requester 0.
REQ-030 During reset, all ready and valid outputs SHALL be 0 and all data outputs SHALL be 0.
REQ-031 Reset mid-operation SHALL discard in-flight and buffered results; no response is produced for them after reset deasserts.

Configuration
REQ-032 Macro SHARED_ARB_RR_EN defined: round-robin per REQ-018.
REQ-033 SHARED_ARB_RR_EN undefined: fixed priority, requester 0 always wins a tie, and the pointer is not implemented; all other behaviour is unchanged.

Verification
REQ-034 Single request: req0 data=5 with resource doubling -> res_in_valid=01 at t, rsp0_valid at t+2 with data=10.
REQ-035 Both requesters continuously valid, RR enabled -> grants alternate 0,1,0,1; responses 2x the operands, each on its own port.
REQ-036 Same stimulus with SHARED_ARB_RR_EN undefined -> requester 0 granted every cycle; req1_ready stays 0.
REQ-037 rsp1_ready=0 while req1 issues data 1,2,3 -> two accepted (responses 2,4 buffered); req1_ready=0 thereafter until a pop; order preserved.
REQ-038 Assert reset with one in-flight and one buffered result -> after reset, all outputs are 0, no stale response appears, and the pointer is 0.
REQ-039 Inject res_out_valid=11 -> no FIFO push occurs and occupancy is unchanged.
